// File: rtl/usb_output.sv
// usb_output: byte FIFO feeding the FT245 write port (wr strobe, data drive enable, txe flow control).
// Build option: define USB_OUTPUT_TXE_SYNC_EN for a two-flop txe synchronizer (default: single register).
module usb_output #(
  parameter int DEPTH_LOG2     = 4,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       newin,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  input  logic       txe,
  output logic       wr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [3:0] state
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int MAX_WAIT = (WR_HIGH_CYCLES > RECOVER_CYCLES) ? WR_HIGH_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_STROBE  = 4'd1;
  localparam logic [3:0] ST_FALL    = 4'd2;
  localparam logic [3:0] ST_RECOVER = 4'd3;

  logic                  txe_s;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push, pop;

  logic [3:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_d, oe_d, load;

  // txe is asynchronous to clk; flops come out of reset as "FTDI not ready".
`ifdef USB_OUTPUT_TXE_SYNC_EN
  logic txe_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
    end else begin
      txe_meta <= txe;
      txe_s    <= txe_meta;
    end
  end
`else
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) txe_s <= 1'b1;
    else       txe_s <= txe;
  end
`endif

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign pop   = (state_q == ST_FALL);
  // A push into a full FIFO survives only when the head leaves in the same cycle.
  assign push  = newin && (!full || pop);

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (newin && full && !pop) overflow <= 1'b1;
    end
  end

  // wr_d/oe_d describe the outputs of the state being entered, so wr and data_oe come straight from flops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    oe_d    = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !txe_s) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
          load    = 1'b1;
          wr_d    = 1'b1;
          oe_d    = 1'b1;
        end
      end
      ST_STROBE: begin
        oe_d = 1'b1;
        if (cnt_q == CNT_W'(WR_HIGH_CYCLES - 1)) begin
          state_d = ST_FALL;
        end else begin
          cnt_d = cnt_q + 1'b1;
          wr_d  = 1'b1;
        end
      end
      ST_FALL: begin
        state_d = ST_RECOVER;
        cnt_d   = '0;
      end
      ST_RECOVER: begin
        if (cnt_q == CNT_W'(RECOVER_CYCLES - 1)) state_d = ST_IDLE;
        else                                      cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr       <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr      <= wr_d;
      data_oe <= oe_d;
      if (load) data_out <= mem[rptr];
    end
  end

  assign state = state_q;

endmodule
